// File: rtl/router_rx_pkg.sv
// rtl/router_rx_pkg.sv - shared types and constants for the router port receiver
package router_rx_pkg;

  localparam int BYTE_W             = 8;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_rx_fifo.sv
// rtl/router_rx_fifo.sv - synchronous FIFO of {last, data} entries
// Pointers carry one extra MSB so full and empty are distinguishable without a count.
module router_rx_fifo
  import router_rx_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/router_port_rx.sv
// rtl/router_port_rx.sv - serial router port receiver: bit reassembly, byte FIFO, packet/error counters
module router_port_rx
  import router_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dout,
  input  logic              valido_n,
  input  logic              frameo_n,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_frame,
  output logic              err_ovf
);

  rx_state_e         state;
  rx_state_e         state_nxt;
  logic              armed;
  logic              capture;
  logic              abort;
  logic              last_bit;
  logic              byte_done;
  logic              frame_err;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] byte_nxt;
  logic              pend_valid;
  fifo_entry_t       pend_entry;
  fifo_entry_t       head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              ovf_drop;
  logic [1:0]        err_inc;
  logic [CNT_W:0]    err_sum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // A packet may only start once frameo_n has been seen high since reset.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!frameo_n && armed) begin
          state_nxt = ST_RECV;
          capture   = ~valido_n;
        end
      end
      ST_RECV: begin
        if (!valido_n) begin
          capture = 1'b1;
          if (frameo_n) state_nxt = ST_IDLE;
        end else if (frameo_n) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign last_bit  = capture & frameo_n;
  assign byte_done = capture & (bit_cnt == 3'd7);
  assign frame_err = abort | (last_bit & ~byte_done);
  assign byte_nxt  = {dout, shift_q[BYTE_W-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed      <= 1'b0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      pend_valid <= 1'b0;
      pend_entry <= '0;
    end else begin
      if (frameo_n) armed <= 1'b1;
      pend_valid <= byte_done;
      if (byte_done) pend_entry <= '{last: last_bit, data: byte_nxt};
      if (abort || last_bit) begin
        bit_cnt <= '0;
        shift_q <= '0;
      end else if (capture) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift_q <= byte_nxt;
      end
    end
  end

  assign pop      = byte_ready & ~fifo_empty;
  assign push     = pend_valid & (~fifo_full | pop);
  assign ovf_drop = pend_valid & fifo_full & ~pop;

  router_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (pend_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign byte_valid = ~fifo_empty;
  assign byte_data  = head.data;
  assign byte_last  = head.last;

  assign err_inc = {1'b0, frame_err} + {1'b0, ovf_drop};
  assign err_sum = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, err_inc};

  // A packet counts only when its final byte actually lands in the FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
      err_frame <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (push && pend_entry.last) pkt_count <= pkt_count + CNT_W'(1);
      err_count <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      err_frame <= frame_err;
      err_ovf   <= ovf_drop;
    end
  end

endmodule

// File: tb/tb_router_port_rx.sv
// tb/tb_router_port_rx.sv - randomized bench for router_port_rx against a packet-level reference model
module tb_router_port_rx;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clock      = 1'b0;
  logic          reset_n    = 1'b0;
  logic          dout       = 1'b0;
  logic          valido_n   = 1'b1;
  logic          frameo_n   = 1'b1;
  logic          byte_ready = 1'b0;
  logic [7:0]    byte_data;
  logic          byte_last;
  logic          byte_valid;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] err_count;
  logic          err_frame;
  logic          err_ovf;

  router_port_rx #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .dout       (dout),
    .valido_n   (valido_n),
    .frameo_n   (frameo_n),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pkt_count  (pkt_count),
    .err_count  (err_count),
    .err_frame  (err_frame),
    .err_ovf    (err_ovf)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  bit rnd_ready = 1'b0;
  int ready_pct = 100;
  int n_frm_seen = 0;
  int n_ovf_seen = 0;

  // Reference model: packet bits collected as a list, FIFO as a queue of {last,data}.
  logic [8:0] m_fifo[$];
  int         m_bits[$];
  bit         m_in_pkt, m_armed, m_pend_v, m_frm, m_ovf;
  logic [8:0] m_pend;
  int         m_pkt, m_err;
  logic [8:0] seen[$];
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_bits.delete();
    m_in_pkt = 0; m_armed = 0; m_pend_v = 0; m_pend = '0;
    m_pkt = 0; m_err = 0; m_frm = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit pop, acc;
    int v;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_frm = 0;
    m_ovf = 0;
    pop = byte_ready && (m_fifo.size() > 0);
    acc = m_pend_v && ((m_fifo.size() < DEPTH) || pop);
    if (m_pend_v && !acc) m_ovf = 1;
    if (pop) void'(m_fifo.pop_front());
    if (acc) begin
      m_fifo.push_back(m_pend);
      if (m_pend[8]) m_pkt++;
    end
    m_pend_v = 0;
    if (!m_in_pkt) begin
      if (!frameo_n && m_armed) begin
        m_in_pkt = 1;
        if (!valido_n) m_bits.push_back(int'(dout));
      end
    end else if (!valido_n) begin
      m_bits.push_back(int'(dout));
      if (m_bits.size() == 8) begin
        v = 0;
        foreach (m_bits[i]) v += m_bits[i] << i;
        m_pend   = {frameo_n, v[7:0]};
        m_pend_v = 1;
        m_bits.delete();
      end else if (frameo_n) begin
        m_frm = 1;
        m_bits.delete();
      end
      if (frameo_n) m_in_pkt = 0;
    end else if (frameo_n) begin
      m_frm = 1;
      m_bits.delete();
      m_in_pkt = 0;
    end
    m_err = m_err + int'(m_frm) + int'(m_ovf);
    if (m_err > CMAX) m_err = CMAX;
    if (frameo_n) m_armed = 1;
  endtask

  always @(posedge clock) model_step();

  always @(negedge clock) begin
    if (cmp_en) begin
      check("byte_valid", 32'(byte_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) check("byte_head", 32'({byte_last, byte_data}), 32'(m_fifo[0]));
      check("pkt_count", 32'(pkt_count), 32'(m_pkt & CMAX));
      check("err_count", 32'(err_count), 32'(m_err));
      check("err_frame", 32'(err_frame), 32'(m_frm));
      check("err_ovf", 32'(err_ovf), 32'(m_ovf));
      if (byte_valid === 1'b1 && byte_ready === 1'b1) seen.push_back({byte_last, byte_data});
      if (err_frame === 1'b1) n_frm_seen++;
      if (err_ovf === 1'b1) n_ovf_seen++;
    end
  end

  task automatic cycle(input logic d, input logic vn, input logic fn);
    dout     = d;
    valido_n = vn;
    frameo_n = fn;
    if (rnd_ready) byte_ready = ($urandom_range(0, 99) < ready_pct);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b1, 1'b1);
  endtask

  task automatic send_bits(input logic [63:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) cycle(bits[i], 1'b0, logic'(i == nbits - 1));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    seen.delete();
    n_frm_seen = 0;
    n_ovf_seen = 0;
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_byte_last", 32'(byte_last), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_err_pulses", 32'({err_frame, err_ovf}), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_seen(input string name);
    check({name, "_count"}, 32'(seen.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      check({name, "_byte"}, (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD, 32'(exp_q[i]));
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    cmp_en = 1'b1;

    // Three-byte packet, consumer always ready
    byte_ready = 1'b1;
    idle(2);
    send_bits(64'hFF3CA5, 24);
    idle(6);
    exp_q = {9'h0A5, 9'h03C, 9'h1FF};
    check_seen("s1");
    check("s1_pkt", 32'(pkt_count), 32'd1);
    check("s1_err", 32'(err_count), 32'd0);
    check("s1_model_pkt", 32'(m_pkt), 32'd1);

    // 12-bit packet: one byte survives, framing error
    do_reset();
    idle(2);
    send_bits(64'hAC3, 12);
    check("s2_err_frame_pulse", 32'(err_frame), 32'd1);
    idle(4);
    exp_q = {9'h0C3};
    check_seen("s2");
    check("s2_pkt", 32'(pkt_count), 32'd0);
    check("s2_err", 32'(err_count), 32'd1);

    // Six bytes into a stalled 4-deep FIFO
    byte_ready = 1'b0;
    do_reset();
    idle(2);
    send_bits(64'h665544332211, 48);
    idle(3);
    check("s3_ovf_pulses", 32'(n_ovf_seen), 32'd2);
    check("s3_err", 32'(err_count), 32'd2);
    check("s3_pkt", 32'(pkt_count), 32'd0);
    check("s3_head", 32'({byte_valid, byte_last, byte_data}), 32'h211);
    byte_ready = 1'b1;
    idle(6);
    exp_q = {9'h011, 9'h022, 9'h033, 9'h044};
    check_seen("s3");

    // Full FIFO, pop in the same cycle as the last push
    byte_ready = 1'b0;
    do_reset();
    idle(2);
    send_bits(64'h0504030201, 40);
    byte_ready = 1'b1;
    idle(8);
    check("s4_ovf_pulses", 32'(n_ovf_seen), 32'd0);
    check("s4_err", 32'(err_count), 32'd0);
    check("s4_pkt", 32'(pkt_count), 32'd1);
    exp_q = {9'h001, 9'h002, 9'h003, 9'h004, 9'h105};
    check_seen("s4");

    // Abort after 5 bits, then a clean one-byte packet
    do_reset();
    idle(2);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    send_bits(64'h81, 8);
    idle(4);
    check("s5_frame_pulses", 32'(n_frm_seen), 32'd1);
    check("s5_err", 32'(err_count), 32'd1);
    check("s5_pkt", 32'(pkt_count), 32'd1);
    exp_q = {9'h181};
    check_seen("s5");

    // Reset mid-packet; tail bits after release must be ignored
    do_reset();
    idle(2);
    send_bits(64'h77, 8);
    frameo_n = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'(i & 1), 1'b0, 1'b0);
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    idle(2);
    send_bits(64'h42, 8);
    idle(4);
    exp_q = {9'h142};
    check_seen("s6");
    check("s6_pkt", 32'(pkt_count), 32'd1);
    check("s6_err", 32'(err_count), 32'd0);

    // Randomized traffic: gaps, aborts, odd lengths, back-to-back, random backpressure
    do_reset();
    rnd_ready = 1'b1;
    for (int p = 0; p < 160; p++) begin
      int len;
      if (p % 40 == 0) ready_pct = (p == 0) ? 90 : (p == 40) ? 25 : (p == 80) ? 60 : 100;
      case ($urandom_range(0, 3))
        0:       len = 8 * $urandom_range(1, 4);
        1:       len = $urandom_range(2, 30);
        default: len = 8 * $urandom_range(1, 6);
      endcase
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 99) < 8) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        if (i > 0 && $urandom_range(0, 99) < 2) begin
          cycle(1'b0, 1'b1, 1'b1);
          break;
        end
        cycle(1'($urandom_range(0, 1)), 1'b0, logic'(i == len - 1));
      end
      repeat ($urandom_range(0, 3)) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    rnd_ready = 1'b0;
    byte_ready = 1'b1;
    idle(12);
    check("drain_empty", 32'(byte_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
